// File: rtl/traffic_signal_colors_pkg.sv
// Shared types for the intersection sequencer: signal colours, phase states,
// the pedestrian sub-phase and the registered bundle of all ten lamp outputs.
package traffic_signal_colors_pkg;

  typedef enum logic [2:0] {
    RED,
    YELLOW,
    GREEN,
    FLASH_RED,
    FLASH_YELLOW
  } color_e;

  typedef enum logic [3:0] {
    NS_TURN,
    NS_TURN_Y,
    NS_GO,
    NS_Y,
    CLR_NS,
    EW_TURN,
    EW_TURN_Y,
    EW_GO,
    EW_Y,
    CLR_EW,
    PREEMPT_HOLD,
    FLASH
  } state_e;

  typedef enum logic [1:0] {
    PED_OFF,
    PED_WALK,
    PED_CLEAR
  } ped_phase_e;

  typedef struct packed {
    color_e sb;
    color_e nb;
    color_e wb;
    color_e eb;
    color_e sb_turn;
    color_e nb_turn;
    color_e wb_turn;
    color_e eb_turn;
    color_e ped_ns;
    color_e ped_ew;
  } lights_t;

  function automatic logic is_go(state_e s);
    return (s == NS_GO) || (s == EW_GO);
  endfunction

  function automatic color_e ped_color(ped_phase_e p);
    case (p)
      PED_WALK:  return GREEN;
      PED_CLEAR: return YELLOW;
      default:   return RED;
    endcase
  endfunction

  // Vehicle lamps for a state; pedestrian lamps are overlaid by the caller.
  function automatic lights_t state_lights(state_e s);
    lights_t l;
    l.sb      = RED;
    l.nb      = RED;
    l.wb      = RED;
    l.eb      = RED;
    l.sb_turn = RED;
    l.nb_turn = RED;
    l.wb_turn = RED;
    l.eb_turn = RED;
    l.ped_ns  = RED;
    l.ped_ew  = RED;
    case (s)
      NS_TURN:   begin l.sb_turn = GREEN;  l.nb_turn = GREEN;  end
      NS_TURN_Y: begin l.sb_turn = YELLOW; l.nb_turn = YELLOW; end
      NS_GO:     begin l.sb = GREEN;       l.nb = GREEN;       end
      NS_Y:      begin l.sb = YELLOW;      l.nb = YELLOW;      end
      EW_TURN:   begin l.wb_turn = GREEN;  l.eb_turn = GREEN;  end
      EW_TURN_Y: begin l.wb_turn = YELLOW; l.eb_turn = YELLOW; end
      EW_GO:     begin l.wb = GREEN;       l.eb = GREEN;       end
      EW_Y:      begin l.wb = YELLOW;      l.eb = YELLOW;      end
      FLASH: begin
        l.sb      = FLASH_YELLOW;
        l.nb      = FLASH_YELLOW;
        l.wb      = FLASH_RED;
        l.eb      = FLASH_RED;
        l.sb_turn = FLASH_RED;
        l.nb_turn = FLASH_RED;
        l.wb_turn = FLASH_RED;
        l.eb_turn = FLASH_RED;
      end
      default: ;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that saturates at zero; done is high while the count
// is zero, i.e. on the last cycle of a loaded duration.
module phase_timer #(
  parameter int               WIDTH       = 6,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             done
);

  logic [WIDTH-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= RESET_VALUE;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/traffic_signal_phase_controller.sv
// Four-way intersection sequencer with protected turns, latched pedestrian
// calls, emergency preemption and night flash; one clock cycle is one second.
module traffic_signal_phase_controller
  import traffic_signal_colors_pkg::*;
#(
  parameter int TURN_TIME      = 10,
  parameter int GREEN_TIME     = 30,
  parameter int YELLOW_TIME    = 4,
  parameter int ALL_RED_TIME   = 2,
  parameter int PED_WALK_TIME  = 7,
  parameter int PED_FLASH_TIME = 10
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   ped_req_ns,
  input  logic   ped_req_ew,
  input  logic   preempt,
  input  logic   flash_mode,
  output color_e signal_sb,
  output color_e signal_nb,
  output color_e signal_wb,
  output color_e signal_eb,
  output color_e signal_sb_turn,
  output color_e signal_nb_turn,
  output color_e signal_wb_turn,
  output color_e signal_eb_turn,
  output color_e ped_signal_ns,
  output color_e ped_signal_ew,
  output logic   ped_pending_ns,
  output logic   ped_pending_ew
);

  localparam int MAX_VEH  = (TURN_TIME > GREEN_TIME) ? TURN_TIME : GREEN_TIME;
  localparam int MAX_CLR  = (YELLOW_TIME > ALL_RED_TIME) ? YELLOW_TIME : ALL_RED_TIME;
  localparam int MAX_PED  = (PED_WALK_TIME > PED_FLASH_TIME) ? PED_WALK_TIME : PED_FLASH_TIME;
  localparam int MAX_VC   = (MAX_VEH > MAX_CLR) ? MAX_VEH : MAX_CLR;
  localparam int MAX_ALL  = (MAX_VC > MAX_PED) ? MAX_VC : MAX_PED;
  localparam int TW       = $clog2(MAX_ALL) + 1;

  localparam logic [TW-1:0] TURN_LOAD      = TW'((TURN_TIME > 0) ? TURN_TIME - 1 : 0);
  localparam logic [TW-1:0] GREEN_LOAD     = TW'(GREEN_TIME - 1);
  localparam logic [TW-1:0] YELLOW_LOAD    = TW'(YELLOW_TIME - 1);
  localparam logic [TW-1:0] ALL_RED_LOAD   = TW'(ALL_RED_TIME - 1);
  localparam logic [TW-1:0] PED_WALK_LOAD  = TW'(PED_WALK_TIME - 1);
  localparam logic [TW-1:0] PED_FLASH_LOAD = TW'(PED_FLASH_TIME - 1);

  state_e          state;
  state_e          state_next;
  logic            phase_load;
  logic [TW-1:0]   phase_load_value;
  logic            phase_done;

  ped_phase_e      ped_phase;
  ped_phase_e      ped_phase_next;
  logic            ped_load;
  logic [TW-1:0]   ped_load_value;
  logic            ped_done;

  logic            pending_ns;
  logic            pending_ew;
  logic            pending_ns_next;
  logic            pending_ew_next;
  logic            entering_ns_go;
  logic            entering_ew_go;
  logic            serve;

  lights_t         lights;
  lights_t         lights_next;

  function automatic logic [TW-1:0] duration_load(state_e s);
    case (s)
      NS_TURN, EW_TURN:                   return TURN_LOAD;
      NS_GO, EW_GO:                       return GREEN_LOAD;
      NS_TURN_Y, EW_TURN_Y, NS_Y, EW_Y:   return YELLOW_LOAD;
      default:                            return ALL_RED_LOAD;
    endcase
  endfunction

  // Phase sequencing; preemption is checked ahead of every other exit.
  // NOTE: next_state defaults to state before the case so no path infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      NS_TURN:   if (preempt || phase_done) state_next = NS_TURN_Y;
      NS_TURN_Y: if (phase_done) state_next = preempt ? PREEMPT_HOLD : NS_GO;
      NS_GO:     if (preempt || phase_done) state_next = NS_Y;
      NS_Y:      if (phase_done) state_next = preempt ? PREEMPT_HOLD : CLR_NS;
      CLR_NS: begin
        if (preempt)             state_next = PREEMPT_HOLD;
        else if (phase_done) begin
          if (flash_mode)        state_next = FLASH;
          else if (TURN_TIME > 0) state_next = EW_TURN;
          else                   state_next = EW_GO;
        end
      end
      EW_TURN:   if (preempt || phase_done) state_next = EW_TURN_Y;
      EW_TURN_Y: if (phase_done) state_next = preempt ? PREEMPT_HOLD : EW_GO;
      EW_GO:     if (preempt || phase_done) state_next = EW_Y;
      EW_Y:      if (phase_done) state_next = preempt ? PREEMPT_HOLD : CLR_EW;
      CLR_EW: begin
        if (preempt)             state_next = PREEMPT_HOLD;
        else if (phase_done) begin
          if (flash_mode)        state_next = FLASH;
          else if (TURN_TIME > 0) state_next = NS_TURN;
          else                   state_next = NS_GO;
        end
      end
      PREEMPT_HOLD: if (!preempt) state_next = CLR_EW;
      FLASH: begin
        if (preempt)           state_next = PREEMPT_HOLD;
        else if (!flash_mode)  state_next = CLR_EW;
      end
      default: state_next = CLR_EW;
    endcase
  end

  // No state ever re-enters itself, so any change of state restarts the timer.
  assign phase_load       = (state_next != state);
  assign phase_load_value = duration_load(state_next);

  always_comb begin
    entering_ns_go  = (state_next == NS_GO) && (state != NS_GO);
    entering_ew_go  = (state_next == EW_GO) && (state != EW_GO);
    pending_ns_next = entering_ns_go ? 1'b0 : (pending_ns | ped_req_ns);
    pending_ew_next = entering_ew_go ? 1'b0 : (pending_ew | ped_req_ew);
    serve = (entering_ns_go && (pending_ns || ped_req_ns)) ||
            (entering_ew_go && (pending_ew || ped_req_ew));

    ped_phase_next = ped_phase;
    ped_load       = 1'b0;
    ped_load_value = PED_WALK_LOAD;
    if (serve) begin
      ped_phase_next = PED_WALK;
      ped_load       = 1'b1;
    end else if (!is_go(state_next)) begin
      // Leaving the green (normally or by preemption) aborts any walk.
      ped_phase_next = PED_OFF;
    end else if (ped_done) begin
      case (ped_phase)
        PED_WALK: begin
          ped_phase_next = PED_CLEAR;
          ped_load       = 1'b1;
          ped_load_value = PED_FLASH_LOAD;
        end
        PED_CLEAR: ped_phase_next = PED_OFF;
        default:   ped_phase_next = PED_OFF;
      endcase
    end

    lights_next = state_lights(state_next);
    if (state_next == NS_GO) lights_next.ped_ns = ped_color(ped_phase_next);
    if (state_next == EW_GO) lights_next.ped_ew = ped_color(ped_phase_next);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= CLR_EW;
      ped_phase  <= PED_OFF;
      pending_ns <= 1'b0;
      pending_ew <= 1'b0;
      lights     <= state_lights(CLR_EW);
    end else begin
      state      <= state_next;
      ped_phase  <= ped_phase_next;
      pending_ns <= pending_ns_next;
      pending_ew <= pending_ew_next;
      lights     <= lights_next;
    end
  end

  phase_timer #(
    .WIDTH       (TW),
    .RESET_VALUE (ALL_RED_LOAD)
  ) u_phase_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (phase_load),
    .load_value (phase_load_value),
    .done       (phase_done)
  );

  phase_timer #(
    .WIDTH       (TW),
    .RESET_VALUE ('0)
  ) u_ped_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (ped_load),
    .load_value (ped_load_value),
    .done       (ped_done)
  );

  assign signal_sb      = lights.sb;
  assign signal_nb      = lights.nb;
  assign signal_wb      = lights.wb;
  assign signal_eb      = lights.eb;
  assign signal_sb_turn = lights.sb_turn;
  assign signal_nb_turn = lights.nb_turn;
  assign signal_wb_turn = lights.wb_turn;
  assign signal_eb_turn = lights.eb_turn;
  assign ped_signal_ns  = lights.ped_ns;
  assign ped_signal_ew  = lights.ped_ew;
  assign ped_pending_ns = pending_ns;
  assign ped_pending_ew = pending_ew;

endmodule

// File: tb/tb_traffic_signal_phase_controller.sv
// Scoreboard bench: a phase-list reference model predicts every cycle's lamps
// and pending flags; a negedge monitor compares them against the controller.
module tb_traffic_signal_phase_controller;
  import traffic_signal_colors_pkg::*;

  localparam int T_TURN   = 10;
  localparam int T_GREEN  = 30;
  localparam int T_YELLOW = 4;
  localparam int T_ALLRED = 2;
  localparam int T_WALK   = 7;
  localparam int T_PFLASH = 10;
  localparam int N_CYCLES = 4000;

  logic   clk;
  logic   reset;
  logic   ped_req_ns;
  logic   ped_req_ew;
  logic   preempt;
  logic   flash_mode;
  color_e signal_sb;
  color_e signal_nb;
  color_e signal_wb;
  color_e signal_eb;
  color_e signal_sb_turn;
  color_e signal_nb_turn;
  color_e signal_wb_turn;
  color_e signal_eb_turn;
  color_e ped_signal_ns;
  color_e ped_signal_ew;
  logic   ped_pending_ns;
  logic   ped_pending_ew;

  traffic_signal_phase_controller #(
    .TURN_TIME      (T_TURN),
    .GREEN_TIME     (T_GREEN),
    .YELLOW_TIME    (T_YELLOW),
    .ALL_RED_TIME   (T_ALLRED),
    .PED_WALK_TIME  (T_WALK),
    .PED_FLASH_TIME (T_PFLASH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .ped_req_ns     (ped_req_ns),
    .ped_req_ew     (ped_req_ew),
    .preempt        (preempt),
    .flash_mode     (flash_mode),
    .signal_sb      (signal_sb),
    .signal_nb      (signal_nb),
    .signal_wb      (signal_wb),
    .signal_eb      (signal_eb),
    .signal_sb_turn (signal_sb_turn),
    .signal_nb_turn (signal_nb_turn),
    .signal_wb_turn (signal_wb_turn),
    .signal_eb_turn (signal_eb_turn),
    .ped_signal_ns  (ped_signal_ns),
    .ped_signal_ew  (ped_signal_ew),
    .ped_pending_ns (ped_pending_ns),
    .ped_pending_ew (ped_pending_ew)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the normal cycle is a list of (kind, axis, duration)
  // phases walked with an elapsed-cycle count; hold and flash sit outside it.
  typedef enum {K_TURN, K_TURN_Y, K_GO, K_Y, K_CLR} kind_e;
  typedef enum {M_SEQ, M_HOLD, M_FLASH} mode_e;
  typedef struct {
    kind_e kind;
    int    axis;
    int    dur;
  } phase_t;

  phase_t      seq[$];
  mode_e       m_mode;
  int          m_idx;
  int          m_t;
  bit          m_entered;
  bit          m_pend[2];
  bit          m_served[2];
  logic [31:0] exp_q[$];
  int          compared;
  int          mismatched;
  int          next_edge;
  int          rst_hold;

  task automatic build_seq();
    for (int a = 0; a < 2; a++) begin
      if (T_TURN > 0) begin
        seq.push_back('{kind: K_TURN,   axis: a, dur: T_TURN});
        seq.push_back('{kind: K_TURN_Y, axis: a, dur: T_YELLOW});
      end
      seq.push_back('{kind: K_GO,  axis: a, dur: T_GREEN});
      seq.push_back('{kind: K_Y,   axis: a, dur: T_YELLOW});
      seq.push_back('{kind: K_CLR, axis: a, dur: T_ALLRED});
    end
  endtask

  task automatic goto_phase(input int i);
    m_idx     = i;
    m_t       = 0;
    m_entered = 1'b1;
  endtask

  task automatic model_reset();
    m_mode      = M_SEQ;
    m_idx       = seq.size() - 1;
    m_t         = 0;
    m_pend[0]   = 1'b0;
    m_pend[1]   = 1'b0;
    m_served[0] = 1'b0;
    m_served[1] = 1'b0;
  endtask

  task automatic model_step(input bit p, input bit f, input bit rn, input bit re);
    bit last;
    bit req;
    int nxt;
    m_entered = 1'b0;
    nxt       = (m_idx + 1) % seq.size();
    case (m_mode)
      M_HOLD: if (!p) begin m_mode = M_SEQ; goto_phase(seq.size() - 1); end
      M_FLASH: begin
        if (p)       m_mode = M_HOLD;
        else if (!f) begin m_mode = M_SEQ; goto_phase(seq.size() - 1); end
      end
      default: begin
        last = (m_t == seq[m_idx].dur - 1);
        case (seq[m_idx].kind)
          K_TURN, K_GO: if (p || last) goto_phase(nxt); else m_t++;
          K_TURN_Y, K_Y: begin
            if (!last)  m_t++;
            else if (p) m_mode = M_HOLD;
            else        goto_phase(nxt);
          end
          default: begin
            if (p)          m_mode = M_HOLD;
            else if (!last) m_t++;
            else if (f)     m_mode = M_FLASH;
            else            goto_phase(nxt);
          end
        endcase
      end
    endcase
    for (int a = 0; a < 2; a++) begin
      req = (a == 0) ? rn : re;
      if (m_mode == M_SEQ && m_entered && seq[m_idx].kind == K_GO && seq[m_idx].axis == a) begin
        m_served[a] = m_pend[a] || req;
        m_pend[a]   = 1'b0;
      end else begin
        m_pend[a] = m_pend[a] || req;
      end
    end
  endtask

  function automatic logic [31:0] model_outputs();
    color_e thr[2];
    color_e trn[2];
    color_e ped[2];
    int     a;
    for (int i = 0; i < 2; i++) begin
      thr[i] = RED;
      trn[i] = RED;
      ped[i] = RED;
    end
    if (m_mode == M_FLASH) begin
      thr[0] = FLASH_YELLOW;
      thr[1] = FLASH_RED;
      trn[0] = FLASH_RED;
      trn[1] = FLASH_RED;
    end else if (m_mode == M_SEQ) begin
      a = seq[m_idx].axis;
      case (seq[m_idx].kind)
        K_TURN:   trn[a] = GREEN;
        K_TURN_Y: trn[a] = YELLOW;
        K_GO:     thr[a] = GREEN;
        K_Y:      thr[a] = YELLOW;
        default:  ;
      endcase
      if (seq[m_idx].kind == K_GO && m_served[a]) begin
        if (m_t < T_WALK)                 ped[a] = GREEN;
        else if (m_t < T_WALK + T_PFLASH) ped[a] = YELLOW;
      end
    end
    return {thr[0], thr[0], thr[1], thr[1], trn[0], trn[0], trn[1], trn[1],
            ped[0], ped[1], m_pend[0], m_pend[1]};
  endfunction

  // Quiet start with the two pedestrian pulses, then a flash window, a
  // preemption window and random bursts of every input.
  task automatic drive_inputs(input int k);
    if (next_edge < 120) begin
      preempt    = 1'b0;
      flash_mode = 1'b0;
      ped_req_ns = (next_edge == 5);
      ped_req_ew = (next_edge == 70);
    end else begin
      if (k >= 300 && k < 440)      flash_mode = 1'b1;
      else if (flash_mode)          flash_mode = ($urandom_range(0, 199) != 0);
      else                          flash_mode = ($urandom_range(0, 899) == 0);
      if (k >= 700 && k < 725)      preempt = 1'b1;
      else if (preempt)             preempt = ($urandom_range(0, 29) != 0);
      else                          preempt = ($urandom_range(0, 349) == 0);
      ped_req_ns = ($urandom_range(0, 24) == 0);
      ped_req_ew = ($urandom_range(0, 24) == 0);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b1;
    preempt    = 1'b0;
    flash_mode = 1'b0;
    ped_req_ns = 1'b0;
    ped_req_ew = 1'b0;
    next_edge  = 0;
    rst_hold   = 2;
    build_seq();
    model_reset();
    for (int k = 0; k < N_CYCLES; k++) begin
      @(posedge clk);
      if (k == 1500 || k == 2800) begin
        // Reset lands mid-cycle, so the monitor sees its immediate effect.
        model_reset();
        exp_q.push_back(model_outputs());
        #1;
        preempt    = 1'b0;
        flash_mode = 1'b0;
        ped_req_ns = 1'b0;
        ped_req_ew = 1'b0;
        #1 reset = 1'b1;
        rst_hold = 2;
      end else if (reset) begin
        exp_q.push_back(model_outputs());
        rst_hold--;
        #1;
        if (rst_hold == 0) begin
          reset     = 1'b0;
          next_edge = 0;
          drive_inputs(k);
        end
      end else begin
        model_step(preempt, flash_mode, ped_req_ns, ped_req_ew);
        exp_q.push_back(model_outputs());
        next_edge++;
        #1 drive_inputs(k);
      end
    end
    @(negedge clk);
    #1;
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin : monitor
    logic [31:0] exp_v;
    logic [31:0] act_v;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        act_v = {signal_sb, signal_nb, signal_wb, signal_eb,
                 signal_sb_turn, signal_nb_turn, signal_wb_turn, signal_eb_turn,
                 ped_signal_ns, ped_signal_ew, ped_pending_ns, ped_pending_ew};
        compared++;
        if (act_v !== exp_v) begin
          mismatched++;
          $display("FAIL outputs at %0t (edge %0d): got %h, required %h",
                   $time, next_edge, act_v, exp_v);
        end
      end
    end
  end

endmodule
